// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : CPU/debug requester ports plus memory-side bus for mem_arbiter
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_halt;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment side: requesters and the memory itself
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (CPU / debug) single-memory arbiter, alternating priority
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE_CPU = 2'd1,
    ST_ISSUE_DBG = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic              last_dbg_q,  last_dbg_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              cpu_rd_q,    cpu_rd_d;
  logic              dbg_rd_q,    dbg_rd_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_elig;
  logic              dbg_elig;

  always_comb begin
    state_d     = ST_IDLE;
    last_dbg_d  = last_dbg_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    // A port just issued cannot win again this edge, which yields alternation
    cpu_elig = bus.cpu_req && !bus.dbg_halt && (state_q != ST_ISSUE_CPU);
    dbg_elig = bus.dbg_req && (state_q != ST_ISSUE_DBG);

    if (cpu_elig && (!dbg_elig || last_dbg_q)) begin
      state_d    = ST_ISSUE_CPU;
      last_dbg_d = 1'b0;
      we_d       = bus.cpu_we;
      addr_d     = bus.cpu_addr;
      wdata_d    = bus.cpu_wdata;
    end else if (dbg_elig) begin
      state_d    = ST_ISSUE_DBG;
      last_dbg_d = 1'b1;
      we_d       = bus.dbg_we;
      addr_d     = bus.dbg_addr;
      wdata_d    = bus.dbg_wdata;
    end

    cpu_rd_d    = (state_q == ST_ISSUE_CPU) && !we_q;
    dbg_rd_d    = (state_q == ST_ISSUE_DBG) && !we_q;
    // Memory data is passed straight through in the rvalid cycle, then held
    cpu_rdata_d = cpu_rd_q ? bus.mem_rdata : cpu_rdata_q;
    dbg_rdata_d = dbg_rd_q ? bus.mem_rdata : dbg_rdata_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      last_dbg_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rd_q    <= 1'b0;
      dbg_rd_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dbg_q  <= last_dbg_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rd_q    <= cpu_rd_d;
      dbg_rd_q    <= dbg_rd_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign bus.cpu_gnt    = (state_q == ST_ISSUE_CPU);
  assign bus.dbg_gnt    = (state_q == ST_ISSUE_DBG);
  assign bus.mem_en     = (state_q != ST_IDLE);
  assign bus.mem_we     = (state_q != ST_IDLE) && we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_rvalid = cpu_rd_q;
  assign bus.dbg_rvalid = dbg_rd_q;
  assign bus.cpu_rdata  = cpu_rdata_d;
  assign bus.dbg_rdata  = dbg_rdata_d;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, address width (256-byte memory).
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req / cpu_we  input  1 each  CPU access request / write qualifier.
REQ-006 cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU access address / write data.
REQ-007 cpu_gnt / cpu_rvalid  output  1 each  CPU grant pulse / read-data-valid pulse.
REQ-008 cpu_rdata  output  DATA_W  CPU read data.
REQ-009 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: debug/loader port, same widths, directions and meanings as the CPU port.
REQ-010 dbg_halt  input  1  when high, CPU is ineligible for grant.
REQ-011 mem_en / mem_we  output  1 each  memory access strobe / write enable.
REQ-012 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address / write data.
REQ-013 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-014 Requester holds req, we, addr and wdata stable from req assertion until the cycle its gnt is high, inclusive; it may deassert req on the edge ending the gnt cycle.
REQ-015 States: IDLE, ISSUE_CPU, ISSUE_DBG; registered, updated every edge.
REQ-016 Eligibility, evaluated each cycle: CPU eligible iff cpu_req=1, dbg_halt=0, state!=ISSUE_CPU; DBG eligible iff dbg_req=1, state!=ISSUE_DBG.
REQ-017 Next state: neither eligible -> IDLE; one eligible -> ISSUE_<that one>; both eligible -> ISSUE_<port not granted most recently>.
REQ-018 last_winner register records the port of every grant; reset value DBG, so first contested grant goes to CPU.
REQ-019 In ISSUE_x: gnt_x=1, mem_en=1, mem_we/mem_addr/mem_wdata = values of port x registered at the edge entering ISSUE_x.
REQ-020 Grant latency: req sampled eligible at edge E -> gnt and mem access during cycle E+1.
REQ-021 Read: if ISSUE_x had we=0, rvalid_x=1 for exactly the following cycle with rdata_x=mem_rdata (registered or direct, but valid for that cycle); writes produce no rvalid.
REQ-022 rdata_x holds its last valid value when rvalid_x=0.
REQ-023 gnt_cpu and gnt_dbg never high in the same cycle; mem_en=0 in IDLE, mem_we=0 whenever mem_en=0.
REQ-024 Throughput: a single port gets at most one access per 2 cycles; two contending ports alternate, giving one access per cycle.
REQ-025 dbg_halt rising while state=ISSUE_CPU: that access completes (including rvalid); no further CPU grant until dbg_halt=0.
REQ-026 Address and data pass through unmodified; no wrap or arithmetic performed.

Reset
REQ-027 reset_n=0 immediately forces state=IDLE, last_winner=DBG, all gnt, rvalid, mem_en, mem_we=0, mem_addr, mem_wdata, cpu_rdata, dbg_rdata=0.
REQ-028 Reset mid-access discards the in-flight access; no rvalid is generated for it after reset release.
REQ-029 First edge after reset_n rises performs normal arbitration.

Verification
REQ-030 CPU read alone: cpu_req=1, cpu_addr=0x10, memory[0x10]=0xA5 -> cpu_gnt next cycle with mem_addr=0x10, mem_en=1, mem_we=0; cpu_rvalid=1, cpu_rdata=0xA5 the cycle after.
REQ-031 Contention: cpu and dbg req together from reset, both held -> grants in order CPU, DBG, CPU, DBG on consecutive cycles; never simultaneous.
REQ-032 dbg write with dbg_halt=1 and cpu_req=1 held: dbg_addr=0x20, dbg_wdata=0x3C -> mem_we=1, mem_addr=0x20, mem_wdata=0x3C; no dbg_rvalid; cpu_gnt stays 0 until dbg_halt=0, then granted within 2 cycles.
REQ-033 Single port back-to-back: cpu_req held high 6 cycles -> cpu_gnt pattern 0,1,0,1,0,1 (one grant per 2 cycles).
REQ-034 Reset in ISSUE_CPU of a read: reset_n=0 for one cycle -> all outputs 0 at once; cpu_rvalid never asserts for that read.
REQ-035 Assertions throughout: gnt one-hot-or-zero, mem_en == (cpu_gnt|dbg_gnt), rvalid only the cycle after a read grant.
